// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: adds two NIBBLES*4-bit operands one nibble per cycle using an
// external combinational 4-bit ripple carry adder, chaining the carry across cycles.
// Results leave over a valid/ready handshake.
// Optional feature: define SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.
module nibble_serial_adder #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   op_cin,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   sum,
`ifdef SERIAL_ADD_OVF_EN
  output logic                   ovf,
`endif
  output logic                   cout
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          r_state;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_c;
  logic            r_carry;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic [CW-1:0]   r_k;
`ifdef SERIAL_ADD_OVF_EN
  logic            r_ovf;
`endif

  logic            w_last;
  logic [CW+1:0]   w_base;

  // Bit offset of the nibble being processed this cycle.
  assign w_base = {r_k, 2'b00};
  assign w_last = (r_k == CW'(NIBBLES - 1));

  // Sequencer: operand capture, per-nibble accumulation and result handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_k     <= '0;
`ifdef SERIAL_ADD_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_c     <= op_cin;
            r_k     <= '0;
            r_state <= StRun;
          end
        end
        StRun: begin
          r_sum[w_base +: 4] <= add_sum;
          r_carry            <= add_cout;
          if (w_last) begin
            r_cout  <= add_cout;
`ifdef SERIAL_ADD_OVF_EN
            // Like-signed operands whose result sign differs have overflowed.
            r_ovf   <= (r_a[W-1] == r_b[W-1]) & (add_sum[3] != r_a[W-1]);
`endif
            r_k     <= '0;
            r_state <= StDone;
          end else begin
            r_k <= r_k + CW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Adder operands: current nibble while running, zero otherwise.
  always_comb begin
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    if (r_state == StRun) begin
      add_a   = r_a[w_base +: 4];
      add_b   = r_b[w_base +: 4];
      add_cin = (r_k == '0) ? r_c : r_carry;
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign sum       = r_sum;
  assign cout      = r_cout;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (NIBBLES=4) with a behavioural 4-bit adder
// on the add_* ports. Define SERIAL_ADD_OVF_EN to also exercise ovf.
module tb_nibble_serial_adder;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          op_cin;
  logic [3:0]    add_a;
  logic [3:0]    add_b;
  logic          add_cin;
  logic [3:0]    add_sum;
  logic          add_cout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
`ifdef SERIAL_ADD_OVF_EN
  logic          ovf;
`endif

  int n_checks;
  int n_errors;

  logic [3:0] rec_a   [N];
  logic [3:0] rec_b   [N];
  logic       rec_cin [N];

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_cin    (op_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef SERIAL_ADD_OVF_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

  // External 4-bit ripple carry adder stand-in.
  always_comb begin
    {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'h0, add_cin};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one operation; called at a negedge with the DUT idle.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input int hold, input logic keep_valid,
                        input logic [W-1:0] exp_sum, input logic exp_cout,
                        input logic exp_ovf);
    chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
    op_a     = a;
    op_b     = b;
    op_cin   = cin;
    in_valid = 1'b1;
    @(negedge clk);
    if (!keep_valid) in_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      rec_a[k]   = add_a;
      rec_b[k]   = add_b;
      rec_cin[k] = add_cin;
      chk({tag, "_out_valid_run"}, 32'(out_valid), 32'd0);
      chk({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    chk({tag, "_out_valid_done"}, 32'(out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    chk({tag, "_cout"}, 32'(cout), 32'(exp_cout));
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) n_errors++;
`endif
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_out_valid_hold"}, 32'(out_valid), 32'd1);
      chk({tag, "_sum_hold"}, 32'(sum), 32'(exp_sum));
      chk({tag, "_cout_hold"}, 32'(cout), 32'(exp_cout));
      chk({tag, "_in_ready_hold"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({tag, "_out_valid_after"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready_after"}, 32'(in_ready), 32'd1);
    chk({tag, "_sum_kept"}, 32'(sum), 32'(exp_sum));
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_cin    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_add_a", 32'(add_a), 32'd0);
    chk("rst_add_b", 32'(add_b), 32'd0);
    chk("rst_add_cin", 32'(add_cin), 32'd0);

    // 1: zero operands
    run_op("t1", 16'h0000, 16'h0000, 1'b0, 0, 1'b0, 16'h0000, 1'b0, 1'b0);

    // 2: full carry ripple across all nibbles
    run_op("t2", 16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 16'h0000, 1'b1, 1'b0);
    chk("t2_cin_k0", 32'(rec_cin[0]), 32'd0);
    for (int k = 1; k < N; k++) chk("t2_cin_chain", 32'(rec_cin[k]), 32'd1);

    // 3: operand nibble order and carry-in
    run_op("t3", 16'h1234, 16'h4321, 1'b1, 0, 1'b0, 16'h5556, 1'b0, 1'b0);
    chk("t3_a0", 32'(rec_a[0]), 32'h4);
    chk("t3_a1", 32'(rec_a[1]), 32'h3);
    chk("t3_a2", 32'(rec_a[2]), 32'h2);
    chk("t3_a3", 32'(rec_a[3]), 32'h1);
    chk("t3_b0", 32'(rec_b[0]), 32'h1);
    chk("t3_b3", 32'(rec_b[3]), 32'h4);
    chk("t3_cin_k0", 32'(rec_cin[0]), 32'd1);
    chk("t3_cin_k1", 32'(rec_cin[1]), 32'd0);

    // 4: back-pressure with in_valid held high
    run_op("t4", 16'hABCD, 16'h1111, 1'b0, 3, 1'b1, 16'hBCDE, 1'b0, 1'b0);

    // 5: reset in the middle of RUN discards the operation
    op_a     = 16'h2222;
    op_b     = 16'h3333;
    op_cin   = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_k2_add_a", 32'(add_a), 32'h2);
    chk("t5_k2_add_b", 32'(add_b), 32'h3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_sum", 32'(sum), 32'd0);
    chk("t5_cout", 32'(cout), 32'd0);
    chk("t5_add_a", 32'(add_a), 32'd0);
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk);
      chk("t5_no_result", 32'(out_valid), 32'd0);
    end

    // 6: signed overflow cases
    run_op("t6a", 16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("t6b", 16'hFFFF, 16'h0001, 1'b0, 1, 1'b0, 16'h0000, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
